mem_arbiter: RTL
================

# mem_arbiter

Shares the single unified memory port between the MIPS core's instruction-fetch port and data port. Each port issues a request and holds it until acknowledged. The arbiter grants one port at a time, drives the memory, waits for the memory's ready response, and returns read data with a one-cycle acknowledge. It sits between the core and the memory inside `top`; `memwrite`, `dataadr` and `writedata` at the `top` boundary are taken from `m_we`, `m_adr` and `m_wdata`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `i_req`  in  1  instruction fetch request (read only)
- `i_adr`  in  AW  fetch address
- `i_rdata`  out  DW  fetched word, valid while `i_ack`=1
- `i_ack`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data access request
- `d_we`  in  1  1 = store, 0 = load
- `d_adr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, valid while `d_ack`=1
- `d_ack`  out  1  one-cycle data completion pulse
- `m_en`  out  1  memory access active
- `m_we`  out  1  memory write strobe; only ever 1 while `m_en`=1
- `m_adr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, sampled when `m_ready`=1
- `m_ready`  in  1  memory completion; ignored while `m_en`=0

## Operation
- FSM states: IDLE, IBUSY, DBUSY. Reset enters IDLE.
- Reset values: `m_en`, `m_we`, `i_ack`, `d_ack` = 0; `m_adr`, `m_wdata`, `i_rdata`, `d_rdata` = 0; `last` = I.
- `last` is a one-bit register recording the most recently granted port.
- **Eligibility in IDLE.** A port is eligible if its `req`=1 and its own `ack` is not 1 in that cycle. This masks the request a requester is still dropping.
- **Arbitration in IDLE:**
  - Only I eligible: go to IBUSY.
  - Only D eligible: go to DBUSY.
  - Both eligible: grant the port not equal to `last` (round-robin).
- **Grant action (registered at the transition edge):**
  - I grant: `m_adr`←`i_adr`, `m_we`←0.
  - D grant: `m_adr`←`d_adr`, `m_wdata`←`d_wdata`, `m_we`←`d_we`.
  - Both: `m_en`←1, `last`←granted port.
- **IBUSY/DBUSY:**
  - `m_en`, `m_adr`, `m_we` and `m_wdata` are held stable.
  - Requester inputs are ignored after the grant.
  - On a cycle with `m_ready`=1, at that edge:
    - `m_en`←0, `m_we`←0.
    - Capture `m_rdata` into the granted port's `rdata`; for a store, capture it too but it is don't-care.
    - Pulse the granted port's `ack` for exactly one cycle.
    - Return to IDLE.
- **`rdata` hold:** `i_rdata`/`d_rdata` keep their last captured value until the next capture.
- **Requester protocol:**
  - Hold `req` and its operands stable until `ack`.
  - Drop `req` in the cycle after `ack`, or keep it high to issue a new access.
  - A new access from the same port is arbitrated one cycle after its `ack`.
- **Reset mid-access:** asynchronous return to IDLE with reset values. The memory access is abandoned, no `ack` is issued, and `m_we` falls immediately.
- An `m_ready` pulse while in IDLE has no effect.

## Timing
- A request first seen by IDLE at edge k drives `m_en`=1 from cycle k+1.
- `m_ready` seen at edge n gives `ack`=1 in cycle n+1, back-to-back with IDLE.
- Minimum request-to-ack latency is 2 cycles (`m_ready` in the first `m_en` cycle).
- Minimum spacing between consecutive grants is 1 IDLE cycle. `m_en` is low for at least one cycle between accesses.
- Worst-case wait for an eligible requester is one full competing access plus 1 cycle (round-robin guarantee).

## Test plan
- **Reset:** drive `reset`=0 with `i_req`=`d_req`=1 → all outputs 0; no `m_en` until 1 cycle after `reset` rises.
- **Single fetch:** `i_req`=1, `i_adr`=0x4; memory returns `m_ready` on the 3rd `m_en` cycle with 0x20020005 → `m_adr`=0x4, `m_we`=0; `i_ack` is a single pulse 1 cycle later with `i_rdata`=0x20020005; total 4 cycles.
- **Store:** `d_req`=1, `d_we`=1, `d_adr`=18, `d_wdata`=21 → `m_we`=1, `m_adr`=18, `m_wdata`=21 only while `m_en`=1; exactly one `d_ack` pulse; `i_ack` stays 0.
- **Contention:** `i_req` and `d_req` rise in the same cycle after reset (`last`=I) → D granted first, then I. With both held continuously, grants alternate D, I, D, I with no starvation.
- **Ack masking:** `d_req` is kept high through the `d_ack` cycle with the same address 84 → exactly one access per request. A second access is granted only after the masked cycle, 2 `m_en` windows for 2 requests.
- **Reset mid-access:** `reset` pulsed low while in DBUSY with `d_we`=1, `d_adr`=0x70f00ff0 → `m_en`/`m_we` drop asynchronously; no `d_ack`; after release a new `d_req` completes normally with `m_wdata`=2.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Core-side request ports and the shared memory port of the memory arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready;

  modport slave (
    input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_adr, m_wdata
  );

  modport master (
    output i_req, i_adr, d_req, d_we, d_adr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_adr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction-fetch
// and data ports of the core; one access in flight, registered outputs.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_adr_q, m_adr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_elig, d_elig, grant_d;

  // A port's own ack masks the request it is still dropping.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_en_d    = m_en_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_elig    = bus.i_req && !i_ack_q;
    d_elig    = bus.d_req && !d_ack_q;
    grant_d   = d_elig && (!i_elig || (last_q == LAST_I));

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          m_en_d = 1'b1;
          if (grant_d) begin
            state_d   = DBUSY;
            last_d    = LAST_D;
            m_adr_d   = AW'(bus.d_adr);
            m_wdata_d = DW'(bus.d_wdata);
            m_we_d    = bus.d_we;
          end else begin
            state_d = IBUSY;
            last_d  = LAST_I;
            m_adr_d = AW'(bus.i_adr);
            m_we_d  = 1'b0;
          end
        end
      end
      IBUSY, DBUSY: begin
        if (bus.m_ready) begin
          state_d = IDLE;
          m_en_d  = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == IBUSY) begin
            i_rdata_d = DW'(bus.m_rdata);
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = DW'(bus.m_rdata);
            d_ack_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_en_d  = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= LAST_I;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_en    = m_en_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_adr   = m_adr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule
